// File: rtl/lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_checker
// Purpose  : Receive end of the 16-bit LFSR test-pattern link. Self-syncs to
//            the incoming word stream (x^16+x^14+x^13+x^11+1, Fibonacci),
//            predicts every next word, reports lock and counts word errors.
// Ports    : clk          system clock
//            rst_n        asynchronous active-low reset
//            chk_en       checker enable (0 = hold everything, ignore din)
//            din_vld      din carries one LFSR word this cycle
//            din[15:0]    received LFSR state word
//            clr          synchronous clear of err_cnt / err_sat / bit_err_cnt
//            lock         1 while the FSM is LOCKED
//            err_pulse    one-cycle pulse per mismatching word while LOCKED
//            err_cnt      saturating mismatching-word count (GP_ERR_W bits)
//            err_sat      sticky: err_cnt reached all-ones
//            bit_err_cnt  saturating bit-error count (only with macro below)
// Config   : LFSR_CHK_BITERR_EN adds bit_err_cnt[23:0] and its logic.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_checker #(
  parameter int GP_LOCK_CNT   = 4,
  parameter int GP_UNLOCK_CNT = 4,
  parameter int GP_ERR_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                chk_en,
  input  logic                din_vld,
  input  logic [15:0]         din,
  input  logic                clr,
  output logic                lock,
  output logic                err_pulse,
  output logic [GP_ERR_W-1:0] err_cnt,
  output logic                err_sat
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [23:0]         bit_err_cnt
`endif
);

  localparam logic [1:0] c_st_hunt   = 2'd0;
  localparam logic [1:0] c_st_sync   = 2'd1;
  localparam logic [1:0] c_st_locked = 2'd2;

  localparam logic [3:0]          c_lock_cnt   = 4'(GP_LOCK_CNT);
  localparam logic [3:0]          c_unlock_cnt = 4'(GP_UNLOCK_CNT);
  localparam logic [GP_ERR_W-1:0] c_err_max    = '1;
  localparam logic [GP_ERR_W-1:0] c_err_one    = {{(GP_ERR_W-1){1'b0}}, 1'b1};

  function automatic logic [15:0] f_nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  logic [1:0]          r_state, w_state_nxt;
  logic [15:0]         r_exp, w_exp_nxt;
  logic [3:0]          r_match_run, w_match_nxt;
  logic [3:0]          r_mis_run, w_mis_nxt;
  logic                r_lock, r_err_pulse, r_err_sat;
  logic [GP_ERR_W-1:0] r_err_cnt, w_err_cnt_nxt;
  logic                w_err_sat_nxt, w_lock_nxt, w_err_hit;
  logic                w_accept, w_match;

  assign w_accept = chk_en & din_vld;
  assign w_match  = (din == r_exp);

  // State register (with the datapath registers that move alongside it)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_hunt;
      r_exp       <= 16'h0000;
      r_match_run <= 4'd0;
      r_mis_run   <= 4'd0;
      r_lock      <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
      r_err_sat   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_exp       <= w_exp_nxt;
      r_match_run <= w_match_nxt;
      r_mis_run   <= w_mis_nxt;
      r_lock      <= w_lock_nxt;
      r_err_pulse <= w_err_hit;
      r_err_cnt   <= w_err_cnt_nxt;
      r_err_sat   <= w_err_sat_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_exp;
    w_match_nxt = r_match_run;
    w_mis_nxt   = r_mis_run;
    w_err_hit   = 1'b0;
    if (w_accept) begin
      case (r_state)
        c_st_hunt: begin
          // All-zero is the LFSR lock-up state and can never be a valid seed
          if (din != 16'h0000) begin
            w_exp_nxt   = f_nxt(din);
            w_match_nxt = 4'd0;
            w_state_nxt = c_st_sync;
          end
        end
        c_st_sync: begin
          w_match_nxt = 4'd0;
          if (w_match) begin
            w_exp_nxt = f_nxt(din);
            if (r_match_run + 4'd1 == c_lock_cnt) begin
              w_state_nxt = c_st_locked;
              w_mis_nxt   = 4'd0;
            end else begin
              w_match_nxt = r_match_run + 4'd1;
            end
          end else if (din == 16'h0000) begin
            w_state_nxt = c_st_hunt;
          end else begin
            w_exp_nxt = f_nxt(din);
          end
        end
        c_st_locked: begin
          // Once locked the prediction free-runs; a bad word never reseeds it
          w_exp_nxt = f_nxt(r_exp);
          if (w_match) begin
            w_mis_nxt = 4'd0;
          end else begin
            w_err_hit = 1'b1;
            if (r_mis_run + 4'd1 == c_unlock_cnt) begin
              w_state_nxt = c_st_hunt;
              w_mis_nxt   = 4'd0;
            end else begin
              w_mis_nxt = r_mis_run + 4'd1;
            end
          end
        end
        default: w_state_nxt = c_st_hunt;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_lock_nxt    = (w_state_nxt == c_st_locked);
    w_err_cnt_nxt = r_err_cnt;
    w_err_sat_nxt = r_err_sat;
    if (clr) begin
      // clr beats a simultaneous error: that error is not counted
      w_err_cnt_nxt = '0;
      w_err_sat_nxt = 1'b0;
    end else if (w_err_hit) begin
      if (r_err_cnt != c_err_max) w_err_cnt_nxt = r_err_cnt + c_err_one;
      w_err_sat_nxt = r_err_sat | (w_err_cnt_nxt == c_err_max);
    end
  end

  assign lock      = r_lock;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;
  assign err_sat   = r_err_sat;

`ifdef LFSR_CHK_BITERR_EN
  function automatic logic [4:0] f_popcount(input logic [15:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) n = n + {4'd0, v[i]};
    return n;
  endfunction

  logic [23:0] r_bit_err_cnt;
  logic [24:0] w_bit_sum;

  assign w_bit_sum = {1'b0, r_bit_err_cnt} + {20'd0, f_popcount(din ^ r_exp)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_err_cnt <= 24'd0;
    end else if (clr) begin
      r_bit_err_cnt <= 24'd0;
    end else if (w_err_hit) begin
      r_bit_err_cnt <= w_bit_sum[24] ? 24'hFFFFFF : w_bit_sum[23:0];
    end
  end

  assign bit_err_cnt = r_bit_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lfsr_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_checker
// Purpose  : Directed self-checking bench for lfsr_checker (GP_ERR_W = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_checker;

  logic        clk;
  logic        rst_n;
  logic        chk_en;
  logic        din_vld;
  logic [15:0] din;
  logic        clr;
  logic        lock;
  logic        err_pulse;
  logic [3:0]  err_cnt;
  logic        err_sat;
`ifdef LFSR_CHK_BITERR_EN
  logic [23:0] bit_err_cnt;
`endif

  int          n_pass = 0;
  int          n_chk  = 0;
  logic [15:0] cur;

  lfsr_checker #(
    .GP_LOCK_CNT  (4),
    .GP_UNLOCK_CNT(4),
    .GP_ERR_W     (4)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .chk_en   (chk_en),
    .din_vld  (din_vld),
    .din      (din),
    .clr      (clr),
    .lock     (lock),
    .err_pulse(err_pulse),
    .err_cnt  (err_cnt),
    .err_sat  (err_sat)
`ifdef LFSR_CHK_BITERR_EN
    ,
    .bit_err_cnt(bit_err_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] f_nxt(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Present one cycle of inputs, let the edge take it, sample 1 ns later.
  task automatic step(input logic [15:0] w, input logic v, input logic e, input logic c);
    @(negedge clk);
    din     = w;
    din_vld = v;
    chk_en  = e;
    clr     = c;
    @(posedge clk);
    #1;
    din_vld = 1'b0;
    clr     = 1'b0;
    chk_en  = 1'b1;
  endtask

  task automatic good();
    step(cur, 1'b1, 1'b1, 1'b0);
    cur = f_nxt(cur);
  endtask

  task automatic bad(input logic c);
    step(cur ^ 16'h0100, 1'b1, 1'b1, c);
    cur = f_nxt(cur);
  endtask

  initial begin
    rst_n   = 1'b0;
    chk_en  = 1'b1;
    din_vld = 1'b0;
    din     = 16'h0000;
    clr     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_lock", {31'd0, lock}, 32'd0);
    chk("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    chk("rst_err_cnt", {28'd0, err_cnt}, 32'd0);
    chk("rst_err_sat", {31'd0, err_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All-zero words in HUNT are ignored
    repeat (3) step(16'h0000, 1'b1, 1'b1, 1'b0);
    chk("hunt_zero_lock", {31'd0, lock}, 32'd0);
    chk("hunt_zero_pulse", {31'd0, err_pulse}, 32'd0);

    // Acquire on stream seeded 0x0001: lock after the 5th word
    cur = 16'h0001;
    repeat (4) good();
    chk("acq_lock_after4", {31'd0, lock}, 32'd0);
    good();
    chk("acq_lock_after5", {31'd0, lock}, 32'd1);
    chk("acq_err_cnt", {28'd0, err_cnt}, 32'd0);

    // Single-bit error while locked: 0x0021 instead of 0x0020
    chk("stream_word5", {16'd0, cur}, 32'h0000_0020);
    step(cur ^ 16'h0001, 1'b1, 1'b1, 1'b0);
    cur = f_nxt(cur);
    chk("single_pulse", {31'd0, err_pulse}, 32'd1);
    chk("single_err_cnt", {28'd0, err_cnt}, 32'd1);
    chk("single_lock", {31'd0, lock}, 32'd1);
`ifdef LFSR_CHK_BITERR_EN
    chk("single_bit_err", {8'd0, bit_err_cnt}, 32'd1);
`endif
    good();
    chk("noreseed_pulse", {31'd0, err_pulse}, 32'd0);
    chk("noreseed_err_cnt", {28'd0, err_cnt}, 32'd1);

    // Four consecutive bad words drop lock
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    chk("clr_err_cnt", {28'd0, err_cnt}, 32'd0);
    repeat (3) bad(1'b0);
    chk("unlock_after3", {31'd0, lock}, 32'd1);
    bad(1'b0);
    chk("unlock_after4", {31'd0, lock}, 32'd0);
    chk("unlock_err_cnt", {28'd0, err_cnt}, 32'd4);
`ifdef LFSR_CHK_BITERR_EN
    chk("unlock_bit_err", {8'd0, bit_err_cnt}, 32'd4);
`endif
    repeat (4) good();
    chk("relock_after4", {31'd0, lock}, 32'd0);
    good();
    chk("relock_after5", {31'd0, lock}, 32'd1);
    chk("relock_err_cnt", {28'd0, err_cnt}, 32'd4);

    // Gaps: din_vld low, then chk_en low with junk on din
    repeat (5) step(16'hBEEF, 1'b0, 1'b1, 1'b0);
    repeat (5) step(16'hDEAD, 1'b1, 1'b0, 1'b0);
    chk("gap_lock", {31'd0, lock}, 32'd1);
    chk("gap_pulse", {31'd0, err_pulse}, 32'd0);
    repeat (3) good();
    chk("resume_err_cnt", {28'd0, err_cnt}, 32'd4);
    chk("resume_pulse", {31'd0, err_pulse}, 32'd0);
    chk("resume_lock", {31'd0, lock}, 32'd1);

    // Saturation of a 4-bit err_cnt over 20 isolated errors
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 20; i++) begin
      bad(1'b0);
      if (i == 13) begin
        chk("sat_cnt_14", {28'd0, err_cnt}, 32'd14);
        chk("sat_flag_14", {31'd0, err_sat}, 32'd0);
      end
      if (i == 14) begin
        chk("sat_cnt_15", {28'd0, err_cnt}, 32'd15);
        chk("sat_flag_15", {31'd0, err_sat}, 32'd1);
      end
      good();
    end
    chk("sat_cnt_end", {28'd0, err_cnt}, 32'd15);
    chk("sat_flag_end", {31'd0, err_sat}, 32'd1);
    chk("sat_lock_end", {31'd0, lock}, 32'd1);
    step(16'h0000, 1'b0, 1'b1, 1'b1);
    chk("satclr_cnt", {28'd0, err_cnt}, 32'd0);
    chk("satclr_flag", {31'd0, err_sat}, 32'd0);
    chk("satclr_lock", {31'd0, lock}, 32'd1);

    // clr in the same cycle as an error: clr wins
    bad(1'b1);
    chk("clr_vs_err_cnt", {28'd0, err_cnt}, 32'd0);
    good();

    // Asynchronous reset mid-stream
    bad(1'b0);
    chk("prerst_pulse", {31'd0, err_pulse}, 32'd1);
    chk("prerst_cnt", {28'd0, err_cnt}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_lock", {31'd0, lock}, 32'd0);
    chk("arst_pulse", {31'd0, err_pulse}, 32'd0);
    chk("arst_cnt", {28'd0, err_cnt}, 32'd0);
    chk("arst_sat", {31'd0, err_sat}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    good();
    chk("postrst_lock", {31'd0, lock}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
